// File: rtl/pll_trim_cal.sv
// pll_trim_cal: open-loop trim calibrator for digital_pll.
// Sweeps a thermometer-coded ext_trim from 0 ones upward. At each step the
// DCO rate is measured by counting transitions of a divided feedback toggle
// over a fixed window. Stops at the first trim whose count is at or below
// target and reports that trim code and count.
//
// Ports
//   osc          reference clock (sole clock)
//   reset        synchronous active-high reset
//   start        level request, sampled only in IDLE
//   target       pass threshold for the window count (stable while busy)
//   fb_tgl       asynchronous divided feedback toggle from the DCO domain
//   pll_resetb   to digital_pll.resetb
//   pll_enable   to digital_pll.enable
//   pll_dco      to digital_pll.dco (1 = open-loop DCO mode)
//   pll_ext_trim to digital_pll.ext_trim, (1<<k)-1
//   busy         calibration in progress
//   done / fail  one-cycle result pulses
//   trim_code    number of ones in the final trim
//   meas_count   count from the final measurement
//
// State | meaning
//   ST_IDLE    | waiting for start, PLL left running at last result
//   ST_PLL_RST | 4 cycles holding the PLL in reset, trim = 0
//   ST_SETTLE  | SETTLE cycles for the DCO to settle after a trim change
//   ST_MEASURE | WINDOW cycles counting feedback transitions
//   ST_COMPARE | one cycle: pass, fail, or advance trim
module pll_trim_cal #(
  parameter int WINDOW = 256,
  parameter int SETTLE = 16,
  parameter int CNT_W  = 12,
  parameter int TRIM_W = 26
) (
  input  logic              osc,
  input  logic              reset,
  input  logic              start,
  input  logic [CNT_W-1:0]  target,
  input  logic              fb_tgl,
  output logic              pll_resetb,
  output logic              pll_enable,
  output logic              pll_dco,
  output logic [TRIM_W-1:0] pll_ext_trim,
  output logic              busy,
  output logic              done,
  output logic              fail,
  output logic [4:0]        trim_code,
  output logic [CNT_W-1:0]  meas_count
);

  localparam int TMR_MAX = (WINDOW > SETTLE) ? WINDOW : SETTLE;
  localparam int TMR_W   = $clog2(TMR_MAX + 4);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PLL_RST,
    ST_SETTLE,
    ST_MEASURE,
    ST_COMPARE
  } state_t;

  state_t             state_q, state_d;
  logic [4:0]         k_q, k_d;
  logic [TMR_W-1:0]   tmr_q, tmr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               s1_q, s2_q, s3_q;
  logic               resetb_q, resetb_d;
  logic               enable_q, enable_d;
  logic               dco_q, dco_d;
  logic [TRIM_W-1:0]  trim_q, trim_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               fail_q, fail_d;
  logic [4:0]         code_q, code_d;
  logic [CNT_W-1:0]   meas_q, meas_d;
  logic               fb_edge;

  // Both toggle directions count; s1 absorbs metastability.
  assign fb_edge = s2_q ^ s3_q;

  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    tmr_d    = tmr_q;
    cnt_d    = cnt_q;
    resetb_d = resetb_q;
    enable_d = enable_q;
    dco_d    = dco_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    fail_d   = 1'b0;
    code_d   = code_q;
    meas_d   = meas_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d  = ST_PLL_RST;
          k_d      = 5'd0;
          tmr_d    = TMR_W'(3);
          resetb_d = 1'b0;
          enable_d = 1'b1;
          dco_d    = 1'b1;
          busy_d   = 1'b1;
        end
      end
      ST_PLL_RST: begin
        if (tmr_q == '0) begin
          state_d  = ST_SETTLE;
          tmr_d    = TMR_W'(SETTLE - 1);
          resetb_d = 1'b1;
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      ST_SETTLE: begin
        if (tmr_q == '0) begin
          state_d = ST_MEASURE;
          tmr_d   = TMR_W'(WINDOW - 1);
          cnt_d   = '0;
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      ST_MEASURE: begin
        // Saturate instead of wrapping so a fast DCO never looks slow.
        if (fb_edge && (cnt_q != {CNT_W{1'b1}})) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
        if (tmr_q == '0) begin
          state_d = ST_COMPARE;
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      ST_COMPARE: begin
        if (cnt_q <= target) begin
          state_d = ST_IDLE;
          code_d  = k_q;
          meas_d  = cnt_q;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end else if (k_q == 5'(TRIM_W)) begin
          state_d = ST_IDLE;
          code_d  = k_q;
          meas_d  = cnt_q;
          fail_d  = 1'b1;
          busy_d  = 1'b0;
        end else begin
          // No PLL reset between steps: only the trim moves.
          state_d = ST_SETTLE;
          k_d     = k_q + 5'd1;
          tmr_d   = TMR_W'(SETTLE - 1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // LSB-first thermometer fill of k ones, registered alongside k.
    trim_d = '0;
    for (int i = 0; i < TRIM_W; i++) begin
      trim_d[i] = (i < int'(k_d));
    end
  end

  always_ff @(posedge osc) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      k_q      <= 5'd0;
      tmr_q    <= '0;
      cnt_q    <= '0;
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      s3_q     <= 1'b0;
      resetb_q <= 1'b0;
      enable_q <= 1'b0;
      dco_q    <= 1'b0;
      trim_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      fail_q   <= 1'b0;
      code_q   <= 5'd0;
      meas_q   <= '0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      tmr_q    <= tmr_d;
      cnt_q    <= cnt_d;
      s1_q     <= fb_tgl;
      s2_q     <= s1_q;
      s3_q     <= s2_q;
      resetb_q <= resetb_d;
      enable_q <= enable_d;
      dco_q    <= dco_d;
      trim_q   <= trim_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      fail_q   <= fail_d;
      code_q   <= code_d;
      meas_q   <= meas_d;
    end
  end

  assign pll_resetb   = resetb_q;
  assign pll_enable   = enable_q;
  assign pll_dco      = dco_q;
  assign pll_ext_trim = trim_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign fail         = fail_q;
  assign trim_code    = code_q;
  assign meas_count   = meas_q;

endmodule

// File: tb/tb_pll_trim_cal.sv
module tb_pll_trim_cal;

  localparam int W = 256;
  localparam int S = 16;
  localparam int BUDGET = 8000;

  logic        osc = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [11:0] target = '0;
  logic        fb_tgl = 1'b0;

  logic        pll_resetb, pll_enable, pll_dco, busy, done, fail;
  logic [25:0] pll_ext_trim;
  logic [4:0]  trim_code;
  logic [11:0] meas_count;

  logic        s_resetb, s_enable, s_dco, s_busy, s_done, s_fail;
  logic [25:0] s_trim;
  logic [4:0]  s_code;
  logic [3:0]  s_meas;

  int tests = 0;
  int failed = 0;
  int fb_a = 4;
  int fb_b = 0;
  int fb_cyc = 0;
  int visited[$];

  pll_trim_cal dut (
    .osc(osc), .reset(reset), .start(start), .target(target), .fb_tgl(fb_tgl),
    .pll_resetb(pll_resetb), .pll_enable(pll_enable), .pll_dco(pll_dco),
    .pll_ext_trim(pll_ext_trim), .busy(busy), .done(done), .fail(fail),
    .trim_code(trim_code), .meas_count(meas_count)
  );

  pll_trim_cal #(.CNT_W(4)) dut_sat (
    .osc(osc), .reset(reset), .start(start), .target(4'd15), .fb_tgl(fb_tgl),
    .pll_resetb(s_resetb), .pll_enable(s_enable), .pll_dco(s_dco),
    .pll_ext_trim(s_trim), .busy(s_busy), .done(s_done), .fail(s_fail),
    .trim_code(s_code), .meas_count(s_meas)
  );

  always #5 osc = ~osc;

  // DCO plant: feedback toggles every fb_a + fb_b*popcount(trim) osc cycles.
  always @(posedge osc) begin
    #2;
    fb_cyc++;
    if (fb_cyc >= fb_a + fb_b * $countones(pll_ext_trim)) begin
      fb_cyc = 0;
      fb_tgl = ~fb_tgl;
    end
  end

  task automatic step();
    @(posedge osc);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_rng(input string tag, input int obs, input int lo, input int hi);
    tests++;
    assert (obs >= lo && obs <= hi) else begin
      failed++;
      $error("FAIL %s observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
    end
  endtask

  // Reference: nominal count at step k is W/P(k) with +-1 tolerance.
  // Returns the first k that surely passes, or fail at k=26; flags a
  // target that sits inside some step's tolerance band.
  function automatic void ref_cal(input int a, input int b, input int tgt,
                                  output int exp_k, output bit exp_pass,
                                  output bit ambiguous, output int lo, output int hi);
    exp_k = 26; exp_pass = 0; ambiguous = 0; lo = 0; hi = 0;
    for (int k = 0; k <= 26; k++) begin
      int p, l, h;
      p = a + b * k;
      l = W / p - 1;
      h = (W + p - 1) / p + 1;
      if (l < 0) l = 0;
      lo = l; hi = h; exp_k = k;
      if (h <= tgt) begin
        exp_pass = 1;
        return;
      end
      if (l <= tgt) ambiguous = 1;
    end
  endfunction

  task automatic run_cal(input int a, input int b, input int tgt, input bit hold,
                         input int pulse_at, output int cyc);
    fb_a = a; fb_b = b; target = 12'(tgt);
    start = 1'b1;
    step();
    if (!hold) start = 1'b0;
    chk("busy_after_start", 32'(busy), 1);
    chk("resetb_after_start", 32'(pll_resetb), 0);
    visited.delete();
    visited.push_back($countones(pll_ext_trim));
    cyc = 0;
    while (cyc < BUDGET && !done && !fail) begin
      if (!hold) start = (cyc == pulse_at);
      step();
      cyc++;
      if (cyc == 3) chk("resetb_low_e3", 32'(pll_resetb), 0);
      if (cyc == 4) chk("resetb_high_e4", 32'(pll_resetb), 1);
      if ($countones(pll_ext_trim) != visited[$]) visited.push_back($countones(pll_ext_trim));
    end
    if (!hold) start = 1'b0;
    chk("run_finished", 32'(done | fail), 1);
  endtask

  task automatic check_result(input string tag, input int a, input int b, input int tgt, input int cyc);
    int ek, lo, hi;
    bit ep, amb;
    ref_cal(a, b, tgt, ek, ep, amb, lo, hi);
    chk({tag, "_done"}, 32'(done), 32'(ep));
    chk({tag, "_fail"}, 32'(fail), 32'(!ep));
    chk({tag, "_cycle"}, 32'(cyc), 32'(5 + S + W + ek * (S + W + 1)));
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_code"}, 32'(trim_code), 32'(ek));
    chk({tag, "_trim"}, 32'(pll_ext_trim), 32'(26'((64'd1 << ek) - 1)));
    chk_rng({tag, "_meas"}, int'(meas_count), lo, hi);
    chk({tag, "_visits"}, 32'(visited.size()), 32'(ek + 1));
    for (int i = 0; i < visited.size(); i++) chk({tag, "_visit_k"}, 32'(visited[i]), 32'(i));
    step();
    chk({tag, "_pulse_done"}, 32'(done), 0);
    chk({tag, "_pulse_fail"}, 32'(fail), 0);
    chk({tag, "_hold_resetb"}, 32'(pll_resetb), 1);
    chk({tag, "_hold_enable"}, 32'(pll_enable), 1);
    chk({tag, "_hold_dco"}, 32'(pll_dco), 1);
    chk({tag, "_hold_code"}, 32'(trim_code), 32'(ek));
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_resetb"}, 32'(pll_resetb), 0);
    chk({tag, "_enable"}, 32'(pll_enable), 0);
    chk({tag, "_dco"}, 32'(pll_dco), 0);
    chk({tag, "_trim"}, 32'(pll_ext_trim), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_fail"}, 32'(fail), 0);
    chk({tag, "_code"}, 32'(trim_code), 0);
    chk({tag, "_meas"}, 32'(meas_count), 0);
  endtask

  initial begin
    int cyc, n, ek, lo, hi, a, b, tgt, tries;
    bit ep, amb;

    // Reset state
    reset = 1'b1;
    step(); step();
    chk_reset_outputs("reset");
    chk("sat_reset_meas", 32'(s_meas), 0);
    reset = 1'b0;
    step();

    // Fixed-rate pass, plus the saturating 4-bit instance on the same stimulus
    run_cal(4, 0, 100, 0, -1, cyc);
    chk("sat_done", 32'(s_done), 1);
    chk("sat_meas", 32'(s_meas), 15);
    chk("sat_code", 32'(s_code), 0);
    chk("fixed_dco", 32'(pll_dco), 1);
    check_result("fixed", 4, 0, 100, cyc);

    // Trim-dependent sweep with a start pulse in SETTLE (must not disturb timing)
    run_cal(2, 1, 30, 0, 10, cyc);
    chk("sweep_code_spec", 32'(trim_code), 7);
    chk("sweep_trim_spec", 32'(pll_ext_trim), 32'h7F);
    check_result("sweep", 2, 1, 30, cyc);

    // Start held across done: a second run starts immediately
    run_cal(2, 1, 30, 1, -1, cyc);
    chk("held_done", 32'(done), 1);
    for (int i = 1; i <= 5; i++) begin
      step();
      chk("held_busy", 32'(busy), 1);
      chk("held_resetb", 32'(pll_resetb), (i == 5) ? 1 : 0);
    end
    chk("held_trim_restart", 32'(pll_ext_trim), 0);
    start = 1'b0;

    // Reset during k=3 MEASURE of that second run
    n = 0;
    while (n < BUDGET && $countones(pll_ext_trim) != 3) begin
      step();
      n++;
    end
    chk("reach_k3", 32'($countones(pll_ext_trim)), 3);
    repeat (S + 20) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk_reset_outputs("midreset");
    repeat (3) step();
    chk("midreset_idle_busy", 32'(busy), 0);
    chk("midreset_idle_resetb", 32'(pll_resetb), 0);
    run_cal(2, 1, 30, 0, -1, cyc);
    check_result("after_reset", 2, 1, 30, cyc);

    // Unreachable target
    run_cal(4, 0, 0, 0, -1, cyc);
    chk("unreach_code_spec", 32'(trim_code), 26);
    check_result("unreach", 4, 0, 0, cyc);

    // Randomized runs against the reference model
    for (int r = 0; r < 3; r++) begin
      a = $urandom_range(3, 6);
      b = $urandom_range(0, 2);
      tries = 0;
      do begin
        tgt = $urandom_range(0, 100);
        ref_cal(a, b, tgt, ek, ep, amb, lo, hi);
        tries++;
      end while (amb && tries < 50);
      if (amb) tgt = 0;
      run_cal(a, b, tgt, 0, -1, cyc);
      check_result("random", a, b, tgt, cyc);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/pll_trim_cal.md
# pll_trim_cal

Open-loop trim calibrator for `digital_pll`. Runs on the PLL reference clock and drives the PLL's `resetb`/`enable`/`dco`/`ext_trim` inputs. It sweeps a thermometer-coded `ext_trim` from 0 ones upward and, at each step, measures the DCO output rate through a divided feedback toggle. It stops at the first trim whose measured count is at or below a programmed target, reporting that trim code and count. It sits beside `digital_pll` in the clocking subsystem and replaces bench-level frequency measurement with an on-chip one.

## Interface
- `WINDOW`, default 256: measurement window length in `osc` cycles.
- `SETTLE`, default 16: settle time in `osc` cycles after every trim change, before measuring.
- `CNT_W`, default 12: width of the edge counter and of `target`.
- `TRIM_W`, default 26: `ext_trim` width (must be 26 for `digital_pll`).
- `osc` in 1: reference clock, the sole clock.
- `reset` in 1: synchronous, active-high reset.
- `start` in 1: level; sampled only in IDLE.
- `target` in CNT_W: pass threshold for the count; held stable while `busy`.
- `fb_tgl` in 1: asynchronous toggle that flips once per 16 `clockp[1]` rising edges (divider lives in the DCO domain). Its transition rate is guaranteed below `osc`/4.
- `pll_resetb` out 1: to `digital_pll.resetb`.
- `pll_enable` out 1: to `digital_pll.enable`.
- `pll_dco` out 1: to `digital_pll.dco` (1 = open-loop DCO mode).
- `pll_ext_trim` out TRIM_W: to `digital_pll.ext_trim`.
- `busy` out 1: high from the cycle after `start` is accepted until the cycle `done`/`fail` rises.
- `done` out 1: one-cycle pulse; calibration passed.
- `fail` out 1: one-cycle pulse; no trim met `target`.
- `trim_code` out 5: number of ones in the final trim, 0..26.
- `meas_count` out CNT_W: count from the final measurement.

## Operation
- Trim encoding: `pll_ext_trim = (1<<k)-1`, with LSB-first thermometer fill and k in 0..TRIM_W. A larger k gives a slower DCO.
- Feedback path:
  - 3-flop chain s1→s2→s3 on `fb_tgl`.
  - edge = s2 XOR s3, so both directions count.
  - The synchronizer runs in every state.
- Counter behaviour:
  - Cleared on entry to MEASURE.
  - Increments on each edge detected during a MEASURE cycle.
  - Saturates at 2^CNT_W-1 and does not wrap.
- States:
  - IDLE: if `start`, set k=0 and go to PLL_RST.
  - PLL_RST: 4 cycles. `pll_resetb`=0, `pll_enable`=1, `pll_dco`=1, trim = k. Then go to SETTLE.
  - SETTLE: SETTLE cycles, with `pll_resetb`=1. Then go to MEASURE.
  - MEASURE: WINDOW cycles of counting. Then go to COMPARE.
  - COMPARE: 1 cycle; the comparison is unsigned.
    - If count ≤ `target`: latch `trim_code`=k and `meas_count`=count, pulse `done` next cycle, go to IDLE.
    - Else if k == TRIM_W: latch k and count, pulse `fail`, go to IDLE.
    - Else: k=k+1, update the trim, go to SETTLE. There is no PLL reset between steps.
- After `done`/`fail`, the PLL stays running: `pll_resetb`=1, `pll_enable`=1, `pll_dco`=1, trim held at the final k, and `trim_code`/`meas_count` held. This persists until the next `start` or `reset`.
- `start` while `busy` is ignored. A `start` held high continuously begins a new run on the first IDLE cycle after `done`/`fail`.
- Reset values, applied at the first `osc` edge with `reset` high, from any state:
  - state IDLE, k=0.
  - `pll_resetb`=0, `pll_enable`=0, `pll_dco`=0, `pll_ext_trim`=0.
  - `busy`=0, `done`=0, `fail`=0, `trim_code`=0, `meas_count`=0.
  - counter and synchronizer flops cleared.

## Timing
- All outputs are registered.
- `start` sampled high at edge E0 → `busy`=1 and `pll_resetb`=0 after E0.
- `pll_resetb` rises after E4.
- A pass at k=0 raises `done` after edge E(5+SETTLE+WINDOW). With defaults that is E277; `busy` falls the same cycle.
- Each additional k step adds SETTLE+WINDOW+1 cycles. The k change is visible on `pll_ext_trim` the cycle after COMPARE.
- Worst case, with `fail`: 5+SETTLE+WINDOW + 26·(SETTLE+WINDOW+1) cycles.
- Synchronizer latency is 3 cycles. Edges in flight at the MEASURE boundary may be lost, so measurement tolerance is ±1 count.

## Test plan
- **Fixed-rate pass:** `fb_tgl` model toggles every 4 `osc` cycles, `target`=100, default parameters → `done` pulse at E277, `trim_code`=0, `meas_count`=64±1, `pll_ext_trim`=0, `pll_dco`=1.
- **Trim-dependent sweep:** `fb_tgl` toggles every 2+popcount(`pll_ext_trim`) cycles, `target`=30 → `done` with `trim_code`=7, `pll_ext_trim`=26'h7F, `meas_count`=28±1. The sweep visits k=0..7 in order.
- **Unreachable target:** `target`=0, `fb_tgl` toggling every 4 cycles → `fail` pulse after the k=26 measurement, `trim_code`=26, `pll_ext_trim` all ones, `done` never asserts.
- **Reset mid-MEASURE:** assert `reset` for 1 cycle during k=3 MEASURE → every output takes its reset value after that edge. A subsequent `start` completes a full run from k=0.
- **Start handling:** pulse `start` during SETTLE → no effect on state or timing. Hold `start` high across `done` → a second run begins the cycle after `done`, with `pll_resetb`=0 for 4 cycles.
- **Counter saturation:** CNT_W=4, `fb_tgl` every 4 cycles, `target`=15 → `meas_count`=15 (saturated, not 64 mod 16) and `done` at k=0.
